// File: rtl/bcd_dabble_conv.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_conv
// Brief    : Sequential binary-to-BCD converter (double dabble), one bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_dabble_conv #(
   parameter int BIN_WIDTH = 16,
   parameter int DIGITS    = 5
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_WIDTH-1:0]  in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  overflow,
   output logic                  busy
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]           r_state;
   logic [1:0]           w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [BIN_WIDTH-1:0] r_shift;
   logic [BCD_W-1:0]     r_acc;
   logic                 r_ovf;
   logic [BCD_W-1:0]     r_out_bcd;
   logic                 r_overflow;

   logic [BCD_W-1:0]     w_adj;
   logic [BCD_W-1:0]     w_acc_next;
   logic [BIN_WIDTH-1:0] w_shift_next;
   logic                 w_carry;
   logic                 w_last;

   // Per-digit add-3 correction; digits never carry into each other.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                          : r_acc[4*i +: 4];
   end

   assign w_carry      = w_adj[BCD_W-1];
   assign w_acc_next   = {w_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
   assign w_shift_next = r_shift << 1;
   assign w_last       = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
         S_SHIFT: if (w_last)    w_next_state = S_DONE;
         S_DONE:  if (out_ready) w_next_state = S_IDLE;
         default:                w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
      out_bcd   = r_out_bcd;
      overflow  = r_overflow;
   end

   // Result registers load only on the final shift so they hold through IDLE/SHIFT.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_out_bcd  <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_shift <= in_bin;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= CNT_LOAD;
               end
            end
            S_SHIFT: begin
               r_shift <= w_shift_next;
               r_acc   <= w_acc_next;
               r_ovf   <= r_ovf | w_carry;
               r_cnt   <= r_cnt - CNT_ONE;
               if (w_last) begin
                  r_out_bcd  <= w_acc_next;
                  r_overflow <= r_ovf | w_carry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
